// File: rtl/rll_key_if.sv
// Key-load, data-in and data-out channels of the RLL key unit.
// Status outputs ride along so the unit has a single bus port.
interface rll_key_if #(
  parameter int LOAD_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
);
  logic                  k_valid;
  logic                  k_ready;
  logic [LOAD_WIDTH-1:0] k_data;
  logic [3:0]            k_chk;
  logic                  key_clear;
  logic                  d_valid;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_data;
  logic                  q_valid;
  logic                  q_ready;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  unlocked;
  logic                  fail_pulse;
  logic                  lockout;
  logic [CNT_WIDTH-1:0]  fail_cnt;

  modport slave (
    input  k_valid, k_data, k_chk, key_clear,
    input  d_valid, d_data, q_ready,
    output k_ready, d_ready, q_valid, q_data,
    output unlocked, fail_pulse, lockout, fail_cnt
  );

  modport master (
    output k_valid, k_data, k_chk, key_clear,
    output d_valid, d_data, q_ready,
    input  k_ready, d_ready, q_valid, q_data,
    input  unlocked, fail_pulse, lockout, fail_cnt
  );
endinterface

// File: rtl/rll_key_unit.sv
// Sequential RLL key unit: serial key load, nibble-fold check,
// retry lockout and a key-gated one-stage data pipeline.
module rll_key_unit #(
  parameter int              KEY_WIDTH  = 16,
  parameter int              LOAD_WIDTH = 4,
  parameter int              DATA_WIDTH = 32,
  parameter logic [KEY_WIDTH-1:0] XNOR_MASK = '0,
  parameter int              MAX_TRIES  = 3
) (
  input logic      clk,
  input logic      rst_n,
  rll_key_if.slave bus
);

  localparam int NB  = KEY_WIDTH / LOAD_WIDTH;
  localparam int NBW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW  = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ACTIVE,
    S_LOCKOUT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [KEY_WIDTH-1:0]  r_key;
  logic [3:0]            r_chk;
  logic [NBW-1:0]        r_beat;
  logic [CW-1:0]         r_fail_cnt;
  logic                  r_fail_pulse;
  logic                  r_q_valid;
  logic [DATA_WIDTH-1:0] r_q_data;

  logic                  w_k_ready;
  logic                  w_d_ready;
  logic                  w_beat_acc;
  logic                  w_last_beat;
  logic                  w_abort;
  logic                  w_d_fire;
  logic [3:0]            w_fold;
  logic                  w_pass;
  logic [DATA_WIDTH-1:0] w_mask;

  assign w_k_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_beat_acc  = bus.k_valid && w_k_ready;
  assign w_last_beat = (r_beat == NBW'(NB - 1));
  assign w_abort     = (r_state == S_LOAD) && bus.key_clear;
  assign w_d_ready   = (r_state == S_ACTIVE) &&
                       (!r_q_valid || bus.q_ready);
  assign w_d_fire    = bus.d_valid && w_d_ready;
  assign w_pass      = (w_fold == r_chk);

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < KEY_WIDTH / 4; i++)
      w_fold = w_fold ^ r_key[i*4 +: 4];
  end

  // Key repeats across the data width; XNOR gates invert their key bit.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      w_mask[i] = r_key[i % KEY_WIDTH] ^ XNOR_MASK[i % KEY_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_beat_acc)
          w_next = (NB == 1) ? S_CHECK : S_LOAD;
      end
      S_LOAD: begin
        if (bus.key_clear)
          w_next = S_IDLE;
        else if (w_beat_acc && w_last_beat)
          w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_pass)
          w_next = S_ACTIVE;
        else if (r_fail_cnt == CW'(MAX_TRIES - 1))
          w_next = S_LOCKOUT;
        else
          w_next = S_IDLE;
      end
      S_ACTIVE: begin
        if (bus.key_clear)
          w_next = S_IDLE;
      end
      S_LOCKOUT: w_next = S_LOCKOUT;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= '0;
      r_chk        <= '0;
      r_beat       <= '0;
      r_fail_cnt   <= '0;
      r_fail_pulse <= 1'b0;
    end else begin
      r_fail_pulse <= 1'b0;
      if (w_beat_acc && !w_abort) begin
        r_key[r_beat*LOAD_WIDTH +: LOAD_WIDTH] <= bus.k_data;
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        if (r_state == S_IDLE)
          r_chk <= bus.k_chk;
      end
      if (w_abort) begin
        r_key  <= '0;
        r_beat <= '0;
      end
      if (r_state == S_CHECK) begin
        if (w_pass) begin
          r_fail_cnt <= '0;
        end else begin
          r_fail_pulse <= 1'b1;
          r_fail_cnt   <= r_fail_cnt + 1'b1;
          r_key        <= '0;
        end
      end
      if (r_state == S_ACTIVE && bus.key_clear)
        r_key <= '0;
    end
  end

  // A key_clear in ACTIVE drops the pending word along with the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_q_data  <= '0;
    end else if (r_state == S_ACTIVE && !bus.key_clear) begin
      if (w_d_fire) begin
        r_q_valid <= 1'b1;
        r_q_data  <= bus.d_data ^ w_mask;
      end else if (bus.q_ready) begin
        r_q_valid <= 1'b0;
      end
    end else begin
      r_q_valid <= 1'b0;
      r_q_data  <= '0;
    end
  end

  assign bus.k_ready    = w_k_ready;
  assign bus.d_ready    = w_d_ready;
  assign bus.q_valid    = r_q_valid;
  assign bus.q_data     = r_q_data;
  assign bus.unlocked   = (r_state == S_ACTIVE);
  assign bus.lockout    = (r_state == S_LOCKOUT);
  assign bus.fail_pulse = r_fail_pulse;
  assign bus.fail_cnt   = r_fail_cnt;

endmodule

// File: doc/rll_key_unit.md
Name: rll_key_unit

Overview:
Sequential successor to our combinational random-logic-locked (RLL) benchmarks. It loads the key serially and verifies it with a nibble-fold check value. Once verified, it applies parametrised XOR/XNOR key gating to a handshaked, one-stage-pipelined data path. Failed attempts are counted, and the block locks out permanently after MAX_TRIES failures.

Parameters:
- KEY_WIDTH, 16, key bits; must be a multiple of 4 and of LOAD_WIDTH.
- LOAD_WIDTH, 4, key bits accepted per load beat.
- DATA_WIDTH, 32, gated data path width.
- XNOR_MASK, {KEY_WIDTH{1'b0}}, per-key-bit gate polarity; 1 = XNOR gate, 0 = XOR gate.
- MAX_TRIES, 3, failed checks allowed before lockout; must be at least 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- k_valid  in  1  key beat valid.
- k_ready  out  1  key beat ready.
- k_data  in  LOAD_WIDTH  key beat, least-significant chunk first.
- k_chk  in  4  expected fold value; sampled with the first beat.
- key_clear  in  1  abort a load, or drop an active key.
- d_valid  in  1  input data valid.
- d_ready  out  1  input data ready.
- d_data  in  DATA_WIDTH  input data.
- q_valid  out  1  output data valid.
- q_ready  in  1  output data ready.
- q_data  out  DATA_WIDTH  gated output data.
- unlocked  out  1  high while in the ACTIVE state.
- fail_pulse  out  1  one-cycle pulse on a failed check.
- lockout  out  1  high while in the LOCKOUT state.
- fail_cnt  out  clog2(MAX_TRIES+1)  failed attempts so far.

Behaviour:
- States: IDLE, LOAD, CHECK, ACTIVE, LOCKOUT.
- Reset values:
  - state = IDLE.
  - key register and beat counter = 0.
  - q_valid = 0, q_data = 0, unlocked = 0, fail_pulse = 0, lockout = 0, fail_cnt = 0.
- Key beat acceptance:
  - k_ready = 1 only in IDLE and LOAD.
  - A beat is accepted when k_valid && k_ready.
  - Beat n writes key[n*LOAD_WIDTH +: LOAD_WIDTH].
- IDLE: an accepted beat stores k_chk, writes beat 0, then goes to LOAD. If KEY_WIDTH == LOAD_WIDTH it goes straight to CHECK.
- LOAD:
  - Accepts beats until KEY_WIDTH/LOAD_WIDTH beats have been taken.
  - The cycle after the last beat, state = CHECK.
  - key_clear in LOAD: return to IDLE, zero the key, fail_cnt unchanged; key_clear has priority over a simultaneous beat.
- CHECK (exactly one cycle):
  - fold = XOR of all KEY_WIDTH/4 key nibbles.
  - fold == stored chk: go to ACTIVE, fail_cnt = 0.
  - Otherwise: fail_pulse = 1 in the following cycle, fail_cnt increments, and the key is zeroed.
  - After a failure, go to LOCKOUT if fail_cnt now equals MAX_TRIES, else to IDLE.
- ACTIVE:
  - unlocked = 1.
  - Data mask bit i = key[i % KEY_WIDTH] ^ XNOR_MASK[i % KEY_WIDTH].
  - d_ready = !q_valid || q_ready.
  - On a d_valid && d_ready handshake, next cycle q_data = d_data ^ mask and q_valid = 1. Latency is 1 cycle.
  - q_valid clears on q_ready when no new input is accepted.
  - Full throughput: one word per cycle while q_ready is held high.
  - q_data is held stable while q_valid && !q_ready.
- key_clear in ACTIVE: next cycle state = IDLE, key zeroed, q_valid cleared (the pending word is dropped), q_data zeroed.
- Outside ACTIVE: d_ready = 0, q_valid = 0, q_data = 0. Ungated data is never emitted.
- LOCKOUT: absorbing until rst_n. k_ready = 0, d_ready = 0, lockout = 1; key_clear is ignored.
- key_clear in IDLE and CHECK: no effect.
- An asynchronous reset at any point, including mid-load or while a word is pending, returns every output to its reset value immediately.

Test Plan:
- Load, default params (XNOR_MASK = 0, KEY = 0xA5C3): beats 3, C, 5, A with k_chk = 0.
  - Expect CHECK 1 cycle after the last beat, then unlocked = 1 and fail_cnt = 0.
  - Then d_data = 0x12345678 gives q_data = 0xB7F7F3BB one cycle later.
- XNOR polarity: same key with XNOR_MASK = 0xFFFF, d_data = 0x12345678 -> q_data = 0x48080C44.
- Backpressure:
  - Stream 4 words with q_ready low for 3 cycles -> q_data held stable, d_ready = 0 while stalled.
  - Then one word per cycle, none lost or duplicated.
- Wrong check: three loads of 0xA5C3 with k_chk = 1.
  - Each gives a fail_pulse, and fail_cnt steps 1, 2, 3.
  - After the third, lockout = 1 and k_ready = 0; a 4th load is ignored.
  - rst_n low clears everything.
- Abort: key_clear after 2 beats -> IDLE, fail_cnt unchanged; a following correct 4-beat load unlocks.
- Drop: key_clear in ACTIVE with a pending q_valid and q_ready = 0 -> next cycle q_valid = 0, unlocked = 0, k_ready = 1.
